// File: rtl/axi_st_rr_arbiter_if.sv
// AXI Stream signal bundle used on both sides of the packet arbiter.
// Widths default to the project-wide AXI_ST_* macros.
`ifndef AXI_ST_SYMBOL_W
`define AXI_ST_SYMBOL_W 8
`endif
`ifndef AXI_ST_SYMBOL_NUM
`define AXI_ST_SYMBOL_NUM 4
`endif
`ifndef AXI_ST_DATA_W
`define AXI_ST_DATA_W (`AXI_ST_SYMBOL_W * `AXI_ST_SYMBOL_NUM)
`endif
`ifndef AXI_ST_TID_W
`define AXI_ST_TID_W 4
`endif
`ifndef AXI_ST_TDEST_W
`define AXI_ST_TDEST_W 4
`endif
`ifndef AXI_ST_TUSER_W
`define AXI_ST_TUSER_W 1
`endif

interface axi_st #(
  parameter int SYMBOL_W   = `AXI_ST_SYMBOL_W,
  parameter int SYMBOL_NUM = `AXI_ST_SYMBOL_NUM,
  parameter int DATA_W     = SYMBOL_W * SYMBOL_NUM,
  parameter int TID_W      = `AXI_ST_TID_W,
  parameter int TDEST_W    = `AXI_ST_TDEST_W,
  parameter int TUSER_W    = `AXI_ST_TUSER_W
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [SYMBOL_NUM-1:0] tstrb;
  logic [SYMBOL_NUM-1:0] tkeep;
  logic                  tlast;
  logic [TID_W-1:0]      tid;
  logic [TDEST_W-1:0]    tdest;
  logic [TUSER_W-1:0]    tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi_st_rr_arbiter.sv
// Packet-level round-robin merge of NUM_IN AXI Stream inputs onto one output.
// A granted input owns the output until its TLAST beat is accepted.
`ifndef AXI_ST_SYMBOL_W
`define AXI_ST_SYMBOL_W 8
`endif
`ifndef AXI_ST_SYMBOL_NUM
`define AXI_ST_SYMBOL_NUM 4
`endif
`ifndef AXI_ST_DATA_W
`define AXI_ST_DATA_W (`AXI_ST_SYMBOL_W * `AXI_ST_SYMBOL_NUM)
`endif
`ifndef AXI_ST_TID_W
`define AXI_ST_TID_W 4
`endif
`ifndef AXI_ST_TDEST_W
`define AXI_ST_TDEST_W 4
`endif
`ifndef AXI_ST_TUSER_W
`define AXI_ST_TUSER_W 1
`endif

module axi_st_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int SYMBOL_W   = `AXI_ST_SYMBOL_W,
  parameter int SYMBOL_NUM = `AXI_ST_SYMBOL_NUM,
  parameter int DATA_W     = `AXI_ST_DATA_W,
  parameter int TID_W      = `AXI_ST_TID_W,
  parameter int TDEST_W    = `AXI_ST_TDEST_W,
  parameter int TUSER_W    = `AXI_ST_TUSER_W,
  parameter int TAG_TID    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_st.slave                      s_axis [NUM_IN],
  axi_st.master                     m_axis,
  output logic [$clog2(NUM_IN)-1:0] grant_idx,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_IN);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  // Elaboration-time sanity checks on the parameter set.
  generate
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
      $error("axi_st_rr_arbiter: NUM_IN must be in 2..16");
    end
    if (DATA_W != SYMBOL_W * SYMBOL_NUM) begin : g_bad_data_w
      $error("axi_st_rr_arbiter: DATA_W must equal SYMBOL_W*SYMBOL_NUM");
    end
    if (TAG_TID != 0 && TID_W < IDX_W) begin : g_bad_tid_w
      $error("axi_st_rr_arbiter: TID_W too narrow to carry the source index");
    end
  endgenerate

  logic [0:0]       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W-1:0] grant_reg, grant_next;

  logic [NUM_IN-1:0]     req;
  logic [NUM_IN-1:0]     s_tlast;
  logic [NUM_IN-1:0]     s_tready;
  logic [DATA_W-1:0]     s_tdata [NUM_IN];
  logic [SYMBOL_NUM-1:0] s_tstrb [NUM_IN];
  logic [SYMBOL_NUM-1:0] s_tkeep [NUM_IN];
  logic [TID_W-1:0]      s_tid   [NUM_IN];
  logic [TDEST_W-1:0]    s_tdest [NUM_IN];
  logic [TUSER_W-1:0]    s_tuser [NUM_IN];

  logic                  out_tvalid;
  logic [DATA_W-1:0]     out_tdata;
  logic [SYMBOL_NUM-1:0] out_tstrb;
  logic [SYMBOL_NUM-1:0] out_tkeep;
  logic                  out_tlast;
  logic [TID_W-1:0]      out_tid;
  logic [TDEST_W-1:0]    out_tdest;
  logic [TUSER_W-1:0]    out_tuser;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic             lock_active;
  logic             last_accept;

  // Flatten the interface array so the granted input can be picked by a
  // run-time index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      assign req[gi]              = s_axis[gi].tvalid;
      assign s_tdata[gi]          = s_axis[gi].tdata;
      assign s_tstrb[gi]          = s_axis[gi].tstrb;
      assign s_tkeep[gi]          = s_axis[gi].tkeep;
      assign s_tlast[gi]          = s_axis[gi].tlast;
      assign s_tid[gi]            = s_axis[gi].tid;
      assign s_tdest[gi]          = s_axis[gi].tdest;
      assign s_tuser[gi]          = s_axis[gi].tuser;
      assign s_axis[gi].tready    = s_tready[gi];
    end
  endgenerate

  // Scan from the far end back towards ptr so the last hit written is the
  // first requester at or after ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_IN)) begin
        cand = cand - (IDX_W + 1)'(NUM_IN);
      end
      if (req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Reset gates the outputs combinationally so nothing handshakes in a
  // cycle where rst is high, whatever the registered state.
  assign lock_active = (state_reg == LOCK) && !rst;

  always_comb begin
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tstrb  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    out_tid    = '0;
    out_tdest  = '0;
    out_tuser  = '0;
    s_tready   = '0;
    if (lock_active) begin
      out_tvalid = req[grant_reg];
      out_tdata  = s_tdata[grant_reg];
      out_tstrb  = s_tstrb[grant_reg];
      out_tkeep  = s_tkeep[grant_reg];
      out_tlast  = s_tlast[grant_reg];
      out_tdest  = s_tdest[grant_reg];
      out_tuser  = s_tuser[grant_reg];
      if (TAG_TID != 0) begin
        out_tid = TID_W'(grant_reg);
      end else begin
        out_tid = s_tid[grant_reg];
      end
      s_tready[grant_reg] = m_axis.tready;
    end
  end

  assign m_axis.tvalid = out_tvalid;
  assign m_axis.tdata  = out_tdata;
  assign m_axis.tstrb  = out_tstrb;
  assign m_axis.tkeep  = out_tkeep;
  assign m_axis.tlast  = out_tlast;
  assign m_axis.tid    = out_tid;
  assign m_axis.tdest  = out_tdest;
  assign m_axis.tuser  = out_tuser;

  assign last_accept = out_tvalid && m_axis.tready && out_tlast;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = LOCK;
          grant_next = win_idx;
          ptr_next   = (win_idx == IDX_W'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      LOCK: begin
        if (last_accept) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
    end
  end

  assign grant_idx = grant_reg;
  assign busy      = (state_reg == LOCK);

endmodule

// File: tb/tb_axi_st_rr_arbiter.sv
// Directed bench for axi_st_rr_arbiter: two instances (TID pass-through and
// TID tagging) see identical traffic from simple per-port packet sources.
module tb_axi_st_rr_arbiter;

  localparam int N = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  tid;
    logic [3:0]  tid2;
    int          cyc;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         mr;
  logic [N-1:0] tv, tl, tr, tr2, fire;
  logic [31:0]  td  [N];
  logic [3:0]   tid [N];
  logic [1:0]   gidx, gidx2;
  logic         busy, busy2;

  int npk [N], len [N], beat [N], pkt [N], gap_at [N], gap_len [N], stall [N];
  int cyc, checks, errors, c_rel;
  rec_t recs [$];

  axi_st s_if  [N] ();
  axi_st m_if  ();
  axi_st s2_if [N] ();
  axi_st m2_if ();

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_src
      assign s_if[gi].tvalid  = tv[gi];
      assign s_if[gi].tdata   = td[gi];
      assign s_if[gi].tstrb   = '1;
      assign s_if[gi].tkeep   = '1;
      assign s_if[gi].tlast   = tl[gi];
      assign s_if[gi].tid     = tid[gi];
      assign s_if[gi].tdest   = 4'(gi);
      assign s_if[gi].tuser   = '0;
      assign s2_if[gi].tvalid = tv[gi];
      assign s2_if[gi].tdata  = td[gi];
      assign s2_if[gi].tstrb  = '1;
      assign s2_if[gi].tkeep  = '1;
      assign s2_if[gi].tlast  = tl[gi];
      assign s2_if[gi].tid    = tid[gi];
      assign s2_if[gi].tdest  = 4'(gi);
      assign s2_if[gi].tuser  = '0;
      assign tr[gi]           = s_if[gi].tready;
      assign tr2[gi]          = s2_if[gi].tready;
    end
  endgenerate

  assign m_if.tready  = mr;
  assign m2_if.tready = mr;

  axi_st_rr_arbiter #(.NUM_IN(N), .TAG_TID(0)) dut (
    .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
    .grant_idx(gidx), .busy(busy)
  );

  axi_st_rr_arbiter #(.NUM_IN(N), .TAG_TID(1)) dut_tag (
    .clk(clk), .rst(rst), .s_axis(s2_if), .m_axis(m2_if),
    .grant_idx(gidx2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  function automatic logic [31:0] expd(input int p, input int k, input int b);
    return {8'(p), 8'(k), 8'(b), 8'hA5};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      tv[i]  = (npk[i] > 0) && (stall[i] == 0);
      td[i]  = expd(i, pkt[i], beat[i]);
      tl[i]  = (beat[i] == len[i] - 1);
      tid[i] = 4'(i + 2);
    end
  endtask

  // One clock: capture handshakes just before the edge, advance sources just
  // after it, return at posedge+3 with the new cycle settled.
  task automatic cycle();
    @(negedge clk);
    #4;
    fire = tv & tr;
    if (m_if.tvalid && mr)
      recs.push_back('{data: m_if.tdata, last: m_if.tlast, tid: m_if.tid,
                       tid2: m2_if.tid, cyc: cyc});
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        beat[i]  = 0;
        stall[i] = 0;
      end else if (fire[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkt[i]++;
          npk[i]--;
        end else begin
          beat[i]++;
        end
        if (beat[i] == gap_at[i] && gap_len[i] > 0) begin
          stall[i]   = gap_len[i];
          gap_len[i] = 0;
        end
      end else if (stall[i] > 0) begin
        stall[i]--;
      end
    end
    drive();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_port [6];
    int rr_pkt  [6];
    rr_port = '{0, 1, 2, 3, 0, 1};
    rr_pkt  = '{0, 0, 0, 0, 1, 1};
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    mr     = 1'b1;
    for (int i = 0; i < N; i++) begin
      len[i] = 3; beat[i] = 0; pkt[i] = 0;
      gap_at[i] = -1; gap_len[i] = 0; stall[i] = 0;
    end
    npk = '{2, 2, 1, 1};
    drive();

    // Reset held 3 cycles with every input valid
    repeat (3) cycle();
    check("rst_tvalid", 64'(m_if.tvalid), 64'(0));
    check("rst_tready", 64'(tr), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(gidx), 64'(0));
    rst = 1'b0;
    cycle();
    c_rel = cyc;
    check("first_grant", 64'(gidx), 64'(0));
    check("first_busy", 64'(busy), 64'(1));
    check("first_tready", 64'(tr), 64'(4'b0001));
    check("first_tdata", 64'(m_if.tdata), 64'(32'h0000_00A5));

    // Round robin, all four ports with 3-beat packets
    repeat (26) cycle();
    check("rr_count", 64'(recs.size()), 64'(18));
    if (recs.size() >= 18) begin
      check("rr_first_cyc", 64'(recs[0].cyc), 64'(c_rel));
      for (int k = 0; k < 18; k++) begin
        check($sformatf("rr_data[%0d]", k), 64'(recs[k].data),
              64'(expd(rr_port[k / 3], rr_pkt[k / 3], k % 3)));
        check($sformatf("rr_last[%0d]", k), 64'(recs[k].last), 64'(k % 3 == 2));
        check($sformatf("rr_cyc[%0d]", k), 64'(recs[k].cyc - recs[0].cyc),
              64'((k / 3) * 4 + k % 3));
      end
    end
    check("rr_end_grant", 64'(gidx), 64'(1));
    check("rr_end_busy", 64'(busy), 64'(0));

    // Lock integrity: port 1 pauses mid-packet while port 2 requests
    recs.delete();
    npk[1] = 1; len[1] = 5; gap_at[1] = 2; gap_len[1] = 2;
    drive();
    cycle();
    check("lock_grant", 64'(gidx), 64'(1));
    npk[2] = 1; len[2] = 3;
    drive();
    repeat (2) cycle();
    check("gap_tvalid", 64'(m_if.tvalid), 64'(0));
    check("gap_tready", 64'(tr), 64'(4'b0010));
    check("gap_busy", 64'(busy), 64'(1));
    check("gap_grant", 64'(gidx), 64'(1));
    repeat (10) cycle();
    check("lock_count", 64'(recs.size()), 64'(8));
    if (recs.size() >= 8) begin
      for (int k = 0; k < 8; k++)
        check($sformatf("lock_data[%0d]", k), 64'(recs[k].data),
              64'((k < 5) ? expd(1, 2, k) : expd(2, 1, k - 5)));
      check("lock_gap_cyc", 64'(recs[2].cyc - recs[1].cyc), 64'(3));
      check("lock_bubble_cyc", 64'(recs[5].cyc - recs[4].cyc), 64'(2));
    end
    check("lock_next_grant", 64'(gidx), 64'(2));

    // Backpressure: TREADY 1,0,0,1 on a 4-beat packet from port 0
    recs.delete();
    npk[0] = 1; len[0] = 4;
    drive();
    cycle();
    check("bp_grant", 64'(gidx), 64'(0));
    mr = 1'b1; #1;
    check("bp_tready0", 64'(tr), 64'(4'b0001));
    check("bp_data0", 64'(m_if.tdata), 64'(expd(0, 2, 0)));
    cycle();
    mr = 1'b0; #1;
    check("bp_tready1", 64'(tr), 64'(4'b0000));
    check("bp_data1", 64'(m_if.tdata), 64'(expd(0, 2, 1)));
    cycle();
    #1;
    check("bp_tready2", 64'(tr), 64'(4'b0000));
    check("bp_hold_valid", 64'(m_if.tvalid), 64'(1));
    check("bp_hold_data", 64'(m_if.tdata), 64'(expd(0, 2, 1)));
    cycle();
    mr = 1'b1; #1;
    check("bp_tready3", 64'(tr), 64'(4'b0001));
    check("bp_data3", 64'(m_if.tdata), 64'(expd(0, 2, 1)));
    repeat (4) cycle();
    check("bp_count", 64'(recs.size()), 64'(4));
    if (recs.size() >= 4)
      for (int k = 0; k < 4; k++)
        check($sformatf("bp_beat[%0d]", k), 64'(recs[k].data), 64'(expd(0, 2, k)));

    // TID pass-through vs tagging on port 3 (source TID 0x5)
    recs.delete();
    npk[3] = 1; len[3] = 2;
    drive();
    cycle();
    check("tid_grant", 64'(gidx), 64'(3));
    check("tag_grant", 64'(gidx2), 64'(3));
    check("tag_busy", 64'(busy2), 64'(1));
    check("tag_tready", 64'(tr2), 64'(4'b1000));
    repeat (3) cycle();
    check("tid_count", 64'(recs.size()), 64'(2));
    if (recs.size() >= 2)
      for (int k = 0; k < 2; k++) begin
        check($sformatf("tid_pass[%0d]", k), 64'(recs[k].tid), 64'(4'h5));
        check($sformatf("tid_tag[%0d]", k), 64'(recs[k].tid2), 64'(4'h3));
      end

    // Reset in the middle of a 4-beat packet from port 2
    npk[2] = 1; len[2] = 4;
    drive();
    cycle();
    check("mr_grant", 64'(gidx), 64'(2));
    repeat (2) cycle();
    rst = 1'b1; #1;
    check("mr_tvalid", 64'(m_if.tvalid), 64'(0));
    check("mr_tag_tvalid", 64'(m2_if.tvalid), 64'(0));
    check("mr_tready", 64'(tr), 64'(0));
    npk[2] = 0;
    cycle();
    check("mr_busy", 64'(busy), 64'(0));
    check("mr_grant_rst", 64'(gidx), 64'(0));
    rst = 1'b0;
    npk[1] = 1; len[1] = 1;
    npk[3] = 1; len[3] = 1;
    drive();
    cycle();
    check("post_rst_grant", 64'(gidx), 64'(1));
    check("single_busy", 64'(busy), 64'(1));
    check("single_last", 64'(m_if.tlast), 64'(1));
    check("single_data", 64'(m_if.tdata), 64'(expd(1, 3, 0)));
    cycle();
    check("single_idle", 64'(busy), 64'(0));
    cycle();
    check("next_grant", 64'(gidx), 64'(3));
    check("next_busy", 64'(busy), 64'(1));
    cycle();
    check("final_idle", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_st_rr_arbiter.md
# axi_st_rr_arbiter

Packet-level round-robin arbiter that merges NUM_IN AXI Stream slave ports onto one AXI Stream master port. Once an input is granted, the arbiter holds it until a complete packet has passed, i.e. until a beat with TLAST is accepted. It sits in front of any shared single-input stream consumer (DMA writer, serializer, output FIFO) in the datapath. Optionally, it tags each beat's TID with the source port index so downstream logic can demultiplex.

## Interface
Parameters:
- NUM_IN, 4 — number of slave inputs; range 2..16.
- SYMBOL_W, `AXI_ST_SYMBOL_W — symbol width; passed to the axi_st instances.
- SYMBOL_NUM, `AXI_ST_SYMBOL_NUM — symbols per beat.
- DATA_W, `AXI_ST_DATA_W — TDATA width.
- TID_W, `AXI_ST_TID_W — TID width; must be ≥ clog2(NUM_IN) when TAG_TID=1.
- TDEST_W, `AXI_ST_TDEST_W — TDEST width.
- TUSER_W, `AXI_ST_TUSER_W — TUSER width.
- TAG_TID, 0 — 1: output TID is replaced by the zero-extended source index; 0: TID passes through.

Ports:
- clk  input  1  — single clock; every register is on its rising edge.
- rst  input  1  — reset; synchronous, active-high.
- s_axis  axi_st.slave  [NUM_IN] array  — requester inputs; index 0..NUM_IN-1.
- m_axis  axi_st.master  1  — merged output stream.
- grant_idx  output  clog2(NUM_IN)  — index of the current or last granted input.
- busy  output  1  — 1 while a packet is locked (state LOCK).

## Operation
- States:
  - IDLE — no grant; all s_axis.TREADY=0; m_axis.TVALID=0.
  - LOCK — one input is connected to the output.
- Arbitration happens in IDLE only, on the request vector req[i] = s_axis[i].TVALID.
- Round-robin pointer ptr:
  - The winner is the first i with req[i]=1, searching ptr, ptr+1, …, wrapping modulo NUM_IN.
  - On a grant, grant_idx ← winner, ptr ← winner+1 (mod NUM_IN), state ← LOCK.
  - No request: stay in IDLE; ptr is unchanged.
- In LOCK, the output is a combinational pass-through of the granted input g:
  - m_axis.TVALID/TDATA/TSTRB/TKEEP/TLAST/TDEST/TUSER = s_axis[g] fields.
  - TID = TAG_TID ? g : s_axis[g].TID.
  - s_axis[g].TREADY = m_axis.TREADY; every other s_axis[i].TREADY = 0.
- Release: a beat with TVALID&TREADY&TLAST on the output moves state to IDLE at the next edge.
- Lock persistence: a granted input that drops TVALID mid-packet keeps the lock. There is no timeout.
- Masking: in IDLE, m_axis data fields are driven 0 with TVALID=0.
- The arbiter never drops, reorders or duplicates beats. Each beat is forwarded exactly once.
- Reset (rst=1 at an edge, any state, including mid-packet): state ← IDLE, ptr ← 0, grant_idx ← 0.
  - Outputs are forced to TVALID=0 and all TREADY=0 in the same cycle rst is high.
  - The partial packet is abandoned. The requester and consumer are reset together with the arbiter.

## Timing
- Arbitration latency: a request seen in IDLE at edge N gives LOCK at edge N. The first beat can transfer in cycle N+1.
- Per-packet overhead: exactly one bubble cycle (IDLE) after each TLAST before the next grant.
  - Peak throughput: L/(L+1) for L-beat packets.
- In LOCK, there is no added latency per beat (zero register stages). m_axis.TREADY→s_axis[g].TREADY is combinational.
- A single-beat packet (TLAST on the first beat) takes LOCK for 1 cycle, then IDLE.
- Fairness: with all inputs continuously requesting, each input gets exactly one packet per NUM_IN grants.
- Simultaneous events: a TLAST accept and new requests in the same cycle → IDLE next cycle. The new arbitration uses the updated ptr.
- AXI rules hold through the arbiter: once m_axis.TVALID=1 in LOCK, it and the data stay stable until TREADY, provided the granted source obeys AXI.
- busy = (state==LOCK). grant_idx is registered and stable for the whole LOCK period.

## Test plan
- Reset values: assert rst for 3 cycles with all inputs valid → m_axis.TVALID=0, all TREADY=0, busy=0, grant_idx=0. First grant after release goes to input 0.
- Round-robin, NUM_IN=4, all inputs continuously sending 3-beat packets → grant order 0,1,2,3,0,1…. Each packet takes 4 cycles (3 beats + 1 bubble). Packets are contiguous and uncorrupted at the output.
- Lock integrity: input 1 sends a 5-beat packet with a 2-cycle TVALID gap after beat 2, while input 2 requests → no beat from input 2 before input 1's TLAST. Then input 2 is granted with ptr=2.
- Backpressure: m_axis.TREADY toggles 1,0,0,1 → granted TREADY mirrors it exactly, data holds stable while stalled, beat count is preserved.
- TAG_TID=1, source TID=0x5 on input 3 → output TID=3 on every beat of that packet. With TAG_TID=0 → output TID=0x5.
- Mid-packet reset: rst after beat 2 of 4 → TVALID=0 the same cycle, IDLE, ptr=0. The next traffic arbitrates from input 0.
